matmul_engine: RTL
==================

Name: matmul_engine

Overview:
- Next-generation matrix multiplier: host loads matrices and header into an internal dual-port RAM, pulses start, and reads the product back after done.
- Generalises the first-generation block:
  - rectangular M x K by K x N operands
  - explicit start/busy/done handshake
  - signed/unsigned mode
  - wide accumulator with optional saturation
  - dimension-error detection
  - deterministic host-port lockout while busy
- Sits at subsystem top; the host sees only a word-addressed memory port plus control/status.

Parameters:
- DATA_WIDTH, 32, element and RAM word width.
- ADDR_WIDTH, 12, RAM address width; depth = 2^ADDR_WIDTH.
- MAX_LEN, 100, maximum legal value of M, K, N.
- MAX_LEN_LOG, 7, bits to hold MAX_LEN.
- ACC_WIDTH, 2*DATA_WIDTH+MAX_LEN_LOG, accumulator width.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1, 1 = clamp result to DATA_WIDTH range, 0 = truncate to low bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- memory_data_in  in  DATA_WIDTH  host write data.
- memory_address  in  ADDR_WIDTH  host word address.
- write_enable  in  1  host write strobe, sampled at clk.
- start  in  1  one-cycle request to begin; honoured only when not busy.
- memory_data_out  out  DATA_WIDTH  host read data, 1-cycle latency.
- busy  out  1  engine owns RAM.
- result_ready  out  1  sticky completion flag.
- dim_error  out  1  sticky: header illegal.
- overflow  out  1  sticky: some result exceeded DATA_WIDTH range.

Behaviour:
- Reset: all outputs 0; FSM to IDLE. RAM contents are not cleared. Reset mid-operation aborts immediately; partial C is left in RAM.
- Memory map, word addresses:
  - 0 = M, 1 = K, 2 = N.
  - A row-major at 3.
  - B row-major at 3+M*K.
  - C row-major at 3+M*K+K*N.
- Host port:
  - Drives RAM port B when busy=0.
  - When busy=1: host writes are dropped; memory_data_out reads 0, never Z or stale.
- start:
  - If start is asserted while busy=1 it is ignored.
  - Accepted start clears result_ready/dim_error/overflow and sets busy at the next edge.
  - Simultaneous start and write_enable in the same cycle: the write completes first, because it is sampled before busy rises.
- FSM, one MAC lane, RAM read latency 1:
  - IDLE: wait for start.
  - HDR0: read words 0 and 1 (ports A, B).
  - HDR1: read word 2; latch M, K.
  - CHECK: latch N. If any dim is 0 or >MAX_LEN, or the C end address is >2^ADDR_WIDTH, set dim_error and go to DONE.
  - CLEAR: acc<=0; i,j,k<=0.
  - MAC:
    - Each cycle issue A[i][k] on port A and B[k][j] on port B.
    - Products accumulate one cycle later.
    - Run K issue cycles.
  - DRAIN: final product accumulates.
  - WRITE: result written to C[i][j] via port B. Advance j, then i. Go to CLEAR, or to DONE after the last element.
  - DONE: busy<=0, result_ready<=1; return to IDLE.
- Timing: cost is K+3 cycles per output element. From the start-accept edge to result_ready high = 3 + M*N*(K+3) + 1 cycles. dim_error path = 4 cycles.
- Arithmetic:
  - Product is 2*DATA_WIDTH wide; sign-extended if SIGNED=1, else zero-extended.
  - Accumulated in ACC_WIDTH; the accumulator never wraps for legal dims.
  - Write-back with SATURATE=1: clamp to [min,max] of a DATA_WIDTH signed or unsigned value, and set overflow if clamped.
  - Write-back with SATURATE=0: take the low DATA_WIDTH bits, and set overflow if the discarded bits are not a pure sign/zero extension.
- Address generation: incremental row/column pointers only, no multipliers in the address path. The C base is computed once in CHECK with one multiply-add pair.

Decomposition:
- Package matmul_pkg:
  - FSM state encoding (IDLE, HDR0, HDR1, CHECK, CLEAR, MAC, DRAIN, WRITE, DONE).
  - Header offsets HDR_M=0, HDR_K=1, HDR_N=2, DATA_BASE=3.
- Sub-module dp_ram: true dual-port, synchronous read, one write port each side, parameters DATA_WIDTH/ADDR_WIDTH.
- Controller, MAC and host mux live in matmul_engine.

Test Plan:
- Identity, 2x2 by 2x2: M=K=N=2, A=[1,2;3,4], B=I -> C at 11..14 = 1,2,3,4; result_ready after 1+3+4*5+1 edges per the formula; overflow=0.
- Rectangular, 1x3 by 3x1: A=[1,2,3], B=[4;5;6] -> C word 9 = 32; busy high exactly 3+1*6+1 cycles.
- Signed, SIGNED=1: A=[-2], B=[7] -> C=0xFFFFFFF2. Saturation with SATURATE=1: A=[0x7FFFFFFF], B=[2] -> C=0x7FFFFFFF, overflow=1.
- Dimension error: M=0 or K=101 -> dim_error=1, result_ready=1 four cycles after start; no writes to RAM.
- Host lockout: during busy, write 0xDEAD to address 3 and read any address -> RAM unchanged, memory_data_out=0. start while busy -> ignored.
- Reset mid-MAC: assert reset -> busy/result_ready immediately 0; a fresh start then completes correctly.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matrix-multiply engine.
//   - state_t   : controller FSM encoding
//   - HDR_*     : word addresses of the M/K/N header in the operand RAM
//   - DATA_BASE : first word of the A matrix
package matmul_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        CHECK,
        CLEAR,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam int HDR_M     = 0;
    localparam int HDR_K     = 1;
    localparam int HDR_N     = 2;
    localparam int DATA_BASE = 3;

endpackage

// File: rtl/dp_ram.sv
// dp_ram: true dual-port RAM with synchronous (1-cycle) read on both ports.
//   clk              : clock
//   we_a/addr_a/din_a: port A write strobe, address, write data
//   dout_a           : port A read data (read-before-write)
//   we_b/addr_b/din_b: port B write strobe, address, write data
//   dout_b           : port B read data (read-before-write)
// On a same-address write collision, port B wins.
module dp_ram
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents
    // survive a reset of the engine.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: C = A x B over an internal dual-port RAM, one MAC lane.
//   clk, reset        : clock, asynchronous active-high reset
//   memory_data_in    : host write data
//   memory_address    : host word address
//   write_enable      : host write strobe
//   start             : one-cycle request to begin (ignored while busy)
//   memory_data_out   : host read data, 1-cycle latency, 0 while busy
//   busy              : engine owns the RAM
//   result_ready      : sticky completion flag
//   dim_error         : sticky, header illegal
//   overflow          : sticky, some result exceeded DATA_WIDTH range
// Memory map: 0=M, 1=K, 2=N, A at 3, B at 3+M*K, C at 3+M*K+K*N.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_LEN     = 100,
    parameter int MAX_LEN_LOG = 7,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH + MAX_LEN_LOG,
    parameter int SIGNED      = 1,
    parameter int SATURATE    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] memory_data_in,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic                  write_enable,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] memory_data_out,
    output logic                  busy,
    output logic                  result_ready,
    output logic                  dim_error,
    output logic                  overflow
);

    // Wide enough for the C end address and for the RAM span itself.
    localparam int EXT_W = (2*MAX_LEN_LOG + 2 > ADDR_WIDTH + 1) ?
                           2*MAX_LEN_LOG + 2 : ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0] ADDR_SPAN = EXT_W'(1) << ADDR_WIDTH;

    state_t                 state;
    logic [MAX_LEN_LOG-1:0] m_dim, k_dim, n_dim;
    logic [MAX_LEN_LOG-1:0] i_cnt, j_cnt, k_cnt;
    logic                   mk_bad, mac_v, host_rd_q;
    logic [ADDR_WIDTH-1:0]  a_row, a_ptr, b_base, b_col, b_ptr, c_ptr;
    logic [ACC_WIDTH-1:0]   acc;

    // RAM ports
    logic [DATA_WIDTH-1:0]  q_a, q_b, ram_din_b;
    logic [ADDR_WIDTH-1:0]  ram_addr_b;
    logic                   ram_we_b;
    logic [ADDR_WIDTH-1:0]  eng_addr_a, eng_addr_b;
    logic                   eng_we_b;

    // Datapath
    logic [2*DATA_WIDTH-1:0] op_a, op_b, prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic                    ovf;
    logic [DATA_WIDTH-1:0]   sat_val, wb_data;
    logic [MAX_LEN_LOG-1:0]  n_new;
    logic [EXT_W-1:0]        b_base_ext, c_base_ext, c_end_ext;
    logic                    hdr_err;

    function automatic logic dim_bad(input logic [DATA_WIDTH-1:0] w);
        return (w == '0) || (w > DATA_WIDTH'(MAX_LEN));
    endfunction

    dp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk    (clk),
        .we_a   (1'b0),
        .addr_a (eng_addr_a),
        .din_a  ('0),
        .dout_a (q_a),
        .we_b   (ram_we_b),
        .addr_b (ram_addr_b),
        .din_b  (ram_din_b),
        .dout_b (q_b)
    );

    // Host owns port B only while idle; engine traffic otherwise.
    assign ram_addr_b      = busy ? eng_addr_b : memory_address;
    assign ram_we_b        = busy ? eng_we_b   : write_enable;
    assign ram_din_b       = busy ? wb_data    : memory_data_in;
    // Only data from a read the host issued while idle is ever shown.
    assign memory_data_out = (host_rd_q && !busy) ? q_b : '0;

    // NOTE: every output of this block gets a default first, so no
    // state leaves a signal unassigned and no latch is inferred.
    always_comb begin
        eng_addr_a = '0;
        eng_addr_b = '0;
        eng_we_b   = 1'b0;
        case (state)
            HDR0: begin
                eng_addr_a = ADDR_WIDTH'(HDR_M);
                eng_addr_b = ADDR_WIDTH'(HDR_K);
            end
            HDR1:  eng_addr_a = ADDR_WIDTH'(HDR_N);
            MAC: begin
                eng_addr_a = a_ptr;
                eng_addr_b = b_ptr;
            end
            WRITE: begin
                eng_addr_b = c_ptr;
                eng_we_b   = 1'b1;
            end
            default: ;
        endcase
    end

    // Header geometry, evaluated in CHECK while N is on port A.
    always_comb begin
        n_new      = q_a[MAX_LEN_LOG-1:0];
        b_base_ext = EXT_W'(DATA_BASE) + EXT_W'(m_dim) * EXT_W'(k_dim);
        c_base_ext = b_base_ext + EXT_W'(k_dim) * EXT_W'(n_new);
        c_end_ext  = c_base_ext + EXT_W'(m_dim) * EXT_W'(n_new);
        hdr_err    = mk_bad || dim_bad(q_a) || (c_end_ext > ADDR_SPAN);
    end

    // Product of the operands on the RAM outputs, extended to the accumulator.
    always_comb begin
        if (SIGNED != 0) begin
            op_a = {{DATA_WIDTH{q_a[DATA_WIDTH-1]}}, q_a};
            op_b = {{DATA_WIDTH{q_b[DATA_WIDTH-1]}}, q_b};
        end else begin
            op_a = {{DATA_WIDTH{1'b0}}, q_a};
            op_b = {{DATA_WIDTH{1'b0}}, q_b};
        end
        prod     = op_a * op_b;
        prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){(SIGNED != 0) && prod[2*DATA_WIDTH-1]}}, prod};
    end

    // Write-back: overflow means the bits above the result are not a pure
    // extension of it; saturation then clamps toward the sign of acc.
    always_comb begin
        if (SIGNED != 0) begin
            ovf     = !((&acc[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc[ACC_WIDTH-1:DATA_WIDTH-1]));
            sat_val = acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            ovf     = |acc[ACC_WIDTH-1:DATA_WIDTH];
            sat_val = '1;
        end
        wb_data = ((SATURATE != 0) && ovf) ? sat_val : acc[DATA_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_ready <= 1'b0;
            dim_error    <= 1'b0;
            overflow     <= 1'b0;
            host_rd_q    <= 1'b0;
            mac_v        <= 1'b0;
            mk_bad       <= 1'b0;
            acc          <= '0;
            m_dim        <= '0;
            k_dim        <= '0;
            n_dim        <= '0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            k_cnt        <= '0;
            a_row        <= '0;
            a_ptr        <= '0;
            b_base       <= '0;
            b_col        <= '0;
            b_ptr        <= '0;
            c_ptr        <= '0;
        end else begin
            host_rd_q <= !busy;
            // Data issued in the previous MAC cycle is on the RAM outputs now.
            mac_v <= (state == MAC);
            if (mac_v) acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        result_ready <= 1'b0;
                        dim_error    <= 1'b0;
                        overflow     <= 1'b0;
                        state        <= HDR0;
                    end
                end
                HDR0: state <= HDR1;
                HDR1: begin
                    m_dim  <= q_a[MAX_LEN_LOG-1:0];
                    k_dim  <= q_b[MAX_LEN_LOG-1:0];
                    mk_bad <= dim_bad(q_a) || dim_bad(q_b);
                    state  <= CHECK;
                end
                CHECK: begin
                    n_dim  <= n_new;
                    b_base <= ADDR_WIDTH'(b_base_ext);
                    b_col  <= ADDR_WIDTH'(b_base_ext);
                    c_ptr  <= ADDR_WIDTH'(c_base_ext);
                    a_row  <= ADDR_WIDTH'(DATA_BASE);
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                    if (hdr_err) begin
                        dim_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    acc   <= '0;
                    k_cnt <= '0;
                    a_ptr <= a_row;
                    b_ptr <= b_col;
                    state <= MAC;
                end
                MAC: begin
                    a_ptr <= a_ptr + ADDR_WIDTH'(1);
                    b_ptr <= b_ptr + ADDR_WIDTH'(n_dim);
                    k_cnt <= k_cnt + MAX_LEN_LOG'(1);
                    if (k_cnt == k_dim - MAX_LEN_LOG'(1)) state <= DRAIN;
                end
                DRAIN: state <= WRITE;
                WRITE: begin
                    if (ovf) overflow <= 1'b1;
                    c_ptr <= c_ptr + ADDR_WIDTH'(1);
                    state <= CLEAR;
                    if (j_cnt == n_dim - MAX_LEN_LOG'(1)) begin
                        j_cnt <= '0;
                        b_col <= b_base;
                        a_row <= a_row + ADDR_WIDTH'(k_dim);
                        i_cnt <= i_cnt + MAX_LEN_LOG'(1);
                        if (i_cnt == m_dim - MAX_LEN_LOG'(1)) state <= DONE;
                    end else begin
                        j_cnt <= j_cnt + MAX_LEN_LOG'(1);
                        b_col <= b_col + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    busy         <= 1'b0;
                    result_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
